// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for IF, trained from ID where control flow resolves.
module branch_target_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] lk_pc,
  output logic                  lk_hit,
  output logic                  lk_taken,
  output logic [ADDR_WIDTH-1:0] lk_target,
  input  logic                  upd_en,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  upd_mispred,
  output logic [CNT_WIDTH-1:0]  upd_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [CNT_WIDTH-1:0]  upd_count_q, mispred_count_q;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, pred_taken;
  logic [1:0]       upd_ctr, ctr_new;
  logic             unused_pc_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

  // Instructions are word aligned, so the byte offset never participates.
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_hit ? target_q[lk_idx] : '0;
  end

  always_comb begin
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr    = ctr_q[upd_idx];
    pred_taken = upd_hit && upd_ctr[1];
    // Gated by rst so the flag drops the instant reset asserts.
    upd_mispred = upd_en && !rst &&
                  ((pred_taken != upd_taken) ||
                   (upd_taken && pred_taken && (target_q[upd_idx] != upd_target)));
    ctr_new = 2'b10;
    if (upd_hit) begin
      if (upd_taken) ctr_new = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
      else           ctr_new = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_en && (upd_hit || upd_taken)) begin
      // A miss that was not taken leaves the table alone.
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      ctr_q[upd_idx]   <= ctr_new;
      if (upd_taken) target_q[upd_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      if (upd_en)      upd_count_q     <= upd_count_q + 1'b1;
      if (upd_mispred) mispred_count_q <= mispred_count_q + 1'b1;
    end
  end

  assign upd_count     = upd_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (default parameters).
// Each vector checks pre-edge outputs, then the clock edge applies its update.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [15:0] upd_count, mispred_count;

  branch_target_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .lk_pc         (lk_pc),
    .lk_hit        (lk_hit),
    .lk_taken      (lk_taken),
    .lk_target     (lk_target),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispred   (upd_mispred),
    .upd_count     (upd_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] lk_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_mis;
    logic [15:0] e_uc;
    logic [15:0] e_mc;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_hit, input logic e_taken,
                             input logic [31:0] e_target, input logic e_mis,
                             input logic [15:0] e_uc, input logic [15:0] e_mc);
    chk({tag, ".lk_hit"},        {31'd0, lk_hit},      {31'd0, e_hit});
    chk({tag, ".lk_taken"},      {31'd0, lk_taken},    {31'd0, e_taken});
    chk({tag, ".lk_target"},     lk_target,            e_target);
    chk({tag, ".upd_mispred"},   {31'd0, upd_mispred}, {31'd0, e_mis});
    chk({tag, ".upd_count"},     {16'd0, upd_count},   {16'd0, e_uc});
    chk({tag, ".mispred_count"}, {16'd0, mispred_count}, {16'd0, e_mc});
  endtask

  initial begin
    //        flush lk_pc        en  upd_pc       tk   upd_target    hit tk  target       mis uc  mc
    vec[0]  = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    0, 0, 32'h0,   0, 0,  0}; // reset state
    vec[1]  = '{0, 32'h40, 1, 32'h40, 1, 32'h100,  0, 0, 32'h0,   1, 0,  0}; // allocate
    vec[2]  = '{0, 32'h40, 1, 32'h40, 0, 32'h0,    1, 1, 32'h100, 1, 1,  1}; // ctr 2->1
    vec[3]  = '{0, 32'h40, 1, 32'h40, 0, 32'h0,    1, 0, 32'h100, 0, 2,  2}; // ctr 1->0
    vec[4]  = '{0, 32'h40, 1, 32'h40, 0, 32'h0,    1, 0, 32'h100, 0, 3,  2}; // ctr stays 0
    vec[5]  = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    1, 0, 32'h100, 0, 4,  2};
    vec[6]  = '{0, 32'h80, 1, 32'h40, 1, 32'h100,  0, 0, 32'h0,   1, 4,  2}; // ctr 0->1
    vec[7]  = '{0, 32'h80, 1, 32'h80, 1, 32'h300,  0, 0, 32'h0,   1, 5,  3}; // alias evicts
    vec[8]  = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    0, 0, 32'h0,   0, 6,  4};
    vec[9]  = '{0, 32'h80, 0, 32'h0,  0, 32'h0,    1, 1, 32'h300, 0, 6,  4};
    vec[10] = '{0, 32'h40, 1, 32'h40, 1, 32'h100,  0, 0, 32'h0,   1, 6,  4}; // re-allocate
    vec[11] = '{0, 32'h40, 1, 32'h40, 1, 32'h200,  1, 1, 32'h100, 1, 7,  5}; // no bypass
    vec[12] = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    1, 1, 32'h200, 0, 8,  6};
    vec[13] = '{0, 32'h44, 1, 32'h40, 1, 32'h200,  0, 0, 32'h0,   0, 8,  6}; // ctr 3 sat
    vec[14] = '{0, 32'h40, 1, 32'h40, 0, 32'h0,    1, 1, 32'h200, 1, 9,  6}; // ctr 3->2
    vec[15] = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    1, 1, 32'h200, 0, 10, 7};
    vec[16] = '{1, 32'h40, 1, 32'h84, 1, 32'h400,  1, 1, 32'h200, 1, 10, 7}; // flush+upd
    vec[17] = '{0, 32'h84, 0, 32'h0,  0, 32'h0,    0, 0, 32'h0,   0, 11, 8};
    vec[18] = '{0, 32'h40, 0, 32'h0,  0, 32'h0,    0, 0, 32'h0,   0, 11, 8};
    vec[19] = '{0, 32'h48, 1, 32'h48, 0, 32'h0,    0, 0, 32'h0,   0, 11, 8}; // miss, NT
    vec[20] = '{0, 32'h48, 0, 32'h0,  0, 32'h0,    0, 0, 32'h0,   0, 12, 8};

    rst = 1'b1; flush = 1'b0; lk_pc = '0; upd_en = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      flush      = vec[i].flush;
      lk_pc      = vec[i].lk_pc;
      upd_en     = vec[i].upd_en;
      upd_pc     = vec[i].upd_pc;
      upd_taken  = vec[i].upd_taken;
      upd_target = vec[i].upd_target;
      @(negedge clk);
      chk_outputs($sformatf("v%0d", i), vec[i].e_hit, vec[i].e_taken, vec[i].e_target,
                  vec[i].e_mis, vec[i].e_uc, vec[i].e_mc);
      @(posedge clk);
      #1;
    end

    // Allocate 0x40, then assert reset mid-cycle with an update pending.
    flush = 1'b0; lk_pc = 32'h40;
    upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    @(posedge clk);
    #1 upd_target = 32'h500;
    #2;
    chk("pre_rst.lk_hit",      {31'd0, lk_hit},      32'd1);
    chk("pre_rst.upd_mispred", {31'd0, upd_mispred}, 32'd1);
    chk("pre_rst.upd_count",   {16'd0, upd_count},   32'd13);
    rst = 1'b1;
    #1;
    chk_outputs("async_rst", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0; upd_en = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("post_rst", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
